// File: rtl/zbt_arbiter.sv
// ZBT SRAM port arbiter: display reads, external writes and a clear sweep
// share one registered SRAM port, with starvation relief for the write side.
module zbt_arbiter #(
  parameter int          LAT         = 2,
  parameter int          STARVE_MAX  = 8,
  parameter logic [35:0] CLEAR_VALUE = 36'hFFFFFFFFF,
  parameter logic [18:0] CLEAR_LAST  = 19'h7FFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd_req,
  input  logic [18:0] rd_addr,
  output logic        rd_ack,
  output logic [35:0] rd_data,
  output logic        rd_valid,
  input  logic        wr_valid,
  input  logic [18:0] wr_addr,
  input  logic [35:0] wr_data,
  output logic        wr_ready,
  input  logic        clear_start,
  output logic        clear_busy,
  output logic        clear_done,
  output logic [18:0] zbt_addr,
  output logic        zbt_we,
  output logic [35:0] zbt_wr_data,
  input  logic [35:0] zbt_rd_data
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [SW-1:0] starve_cnt;
  logic [18:0]   clr_addr;
  logic [LAT:0]  vpipe;

  logic          wr_pend;
  logic          force_wr;
  logic          rd_gnt;
  logic          wr_gnt;
  logic [18:0]   src_addr;
  logic [35:0]   src_data;

  // Write side is forced once it has waited STARVE_MAX cycles
  always_comb begin
    wr_pend  = clear_busy | wr_valid;
    force_wr = wr_pend & (starve_cnt == SW'(STARVE_MAX));
    rd_gnt   = ~reset & rd_req & ~force_wr;
    wr_gnt   = ~reset & wr_pend & (~rd_req | force_wr);
    src_addr = clear_busy ? clr_addr : wr_addr;
    src_data = clear_busy ? CLEAR_VALUE : wr_data;
  end

  assign rd_ack   = rd_gnt;
  assign wr_ready = ~reset & ~clear_busy & (~rd_req | force_wr);
  assign rd_data  = zbt_rd_data;
  assign rd_valid = vpipe[LAT];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (clear_start) state_nx = CLEAR;
      CLEAR:   if (wr_gnt && clr_addr == CLEAR_LAST) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    clear_busy = (state == CLEAR);
    clear_done = (state == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clr_addr <= '0;
    end else if (state == IDLE && clear_start) begin
      clr_addr <= '0;
    end else if (clear_busy && wr_gnt && clr_addr != CLEAR_LAST) begin
      clr_addr <= clr_addr + 19'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (!wr_pend || wr_gnt) begin
      starve_cnt <= '0;
    end else begin
      starve_cnt <= starve_cnt + SW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      zbt_addr    <= '0;
      zbt_we      <= 1'b0;
      zbt_wr_data <= '0;
    end else if (rd_gnt) begin
      zbt_addr    <= rd_addr;
      zbt_we      <= 1'b0;
    end else if (wr_gnt) begin
      zbt_addr    <= src_addr;
      zbt_we      <= 1'b1;
      zbt_wr_data <= src_data;
    end else begin
      zbt_we      <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vpipe <= '0;
    end else begin
      vpipe <= (vpipe << 1) | (LAT+1)'(rd_gnt);
    end
  end

endmodule
